// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester grant stage.
// No logic of its own; sizing constants and the one-hot to index conversion.
package arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot2idx(input logic [NREQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/prio4_onehot.sv
// Highest-index-wins one-hot pick over the eligible request set.
// Purely combinational, zero latency; no flow control.
module prio4_onehot
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  output logic [NREQ-1:0] pick
);

  always_comb begin
    pick = '0;
    if (elig[3])      pick = 4'b1000;
    else if (elig[2]) pick = 4'b0100;
    else if (elig[1]) pick = 4'b0010;
    else if (elig[0]) pick = 4'b0001;
  end

endmodule

// File: rtl/grant_arb4.sv
// Held one-hot grant with done/withdraw/timeout release and timeout lockout.
// Grant appears one cycle after req; release forces a one-cycle idle gap before the next grant.
module grant_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [1:0]      gnt_id,
  output logic            timeout,
  output logic [NREQ-1:0] lock
);

  localparam bit             HOLD_EN = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] lock_set;
  logic            rel_done;
  logic            rel_wdraw;
  logic            rel_to;
  logic            force_rel;

  assign elig = req & ~lock;

  prio4_onehot u_prio (
    .elig (elig),
    .pick (pick)
  );

  assign rel_done  = done;
  assign rel_wdraw = ~req[gnt_id];
  assign rel_to    = HOLD_EN && (cnt == CNT_LIM);
  // done and withdrawal both outrank the timeout, so only a clean expiry locks out
  assign force_rel = (state == ARB_BUSY) && !rel_done && !rel_wdraw && rel_to;
  assign lock_set  = force_rel ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      lock      <= '0;
      cnt       <= '0;
    end else begin
      timeout <= force_rel;
      lock    <= (lock | lock_set) & req;
      case (state)
        ARB_IDLE: begin
          if (|elig) begin
            gnt       <= pick;
            gnt_valid <= 1'b1;
            gnt_id    <= onehot2idx(pick);
            cnt       <= '0;
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (rel_done || rel_wdraw || rel_to) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            cnt       <= '0;
            state     <= ARB_IDLE;
          end else if (cnt != CNT_LIM) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_arb4.sv
// Directed plus random checks of grant_arb4 against a cycle-level reference model.
module tb_grant_arb4;

  localparam int MH = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;
  logic [3:0] lock;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the grant, for how many visible cycles, lockouts
  int         m_owner;
  int         m_held;
  logic [3:0] m_lock;
  logic       m_to;

  grant_arb4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout),
    .lock      (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_lock  = 4'b0000;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (d) m_owner = -1;
      else if (!r[m_owner]) m_owner = -1;
      else if (MH != 0 && m_held == MH) begin
        m_lock[m_owner] = 1'b1;
        m_to    = 1'b1;
        m_owner = -1;
      end else m_held++;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (m_owner < 0 && r[i] && !m_lock[i]) begin
          m_owner = i;
          m_held  = 1;
        end
      end
    end
    for (int i = 0; i < 4; i++) if (!r[i]) m_lock[i] = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] eg;
    logic [1:0] eid;
    eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    chk({tag, ".gnt"}, 8'(gnt), 8'(eg));
    chk({tag, ".gnt_valid"}, 8'(gnt_valid), 8'(eg != 4'b0000));
    chk({tag, ".gnt_id"}, 8'(gnt_id), 8'(eid));
    chk({tag, ".timeout"}, 8'(timeout), 8'(m_to));
    chk({tag, ".lock"}, 8'(lock), 8'(m_lock));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(req, done);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    req   = 4'b0101;
    done  = 1'b0;

    #12;
    compare_all("reset");
    rst_n = 1'b1;

    // basic grant and done release
    cyc("grant0");
    chk("basic_gnt", 8'(gnt), 8'h04);
    chk("basic_id", 8'(gnt_id), 8'h02);
    done = 1'b1;
    req  = 4'b0001;
    cyc("done_gap");
    chk("done_gap_gnt", 8'(gnt), 8'h00);
    done = 1'b0;
    cyc("regrant");
    chk("regrant_gnt", 8'(gnt), 8'h01);

    // no preemption by a higher-priority request
    req = 4'b1001;
    cyc("nopre1");
    cyc("nopre2");
    chk("nopre_gnt", 8'(gnt), 8'h01);
    done = 1'b1;
    cyc("nopre_rel");
    done = 1'b0;
    cyc("nopre_next");
    chk("nopre_next_gnt", 8'(gnt), 8'h08);

    // withdrawal
    req = 4'b0100;
    cyc("wd_rel3");
    cyc("wd_grant2");
    chk("wd_gnt2", 8'(gnt), 8'h04);
    req = 4'b0000;
    cyc("wd_drop");
    chk("wd_gnt", 8'(gnt), 8'h00);
    chk("wd_timeout", 8'(timeout), 8'h00);

    // timeout and lockout
    req = 4'b1010;
    cyc("to_c1");
    cyc("to_c2");
    cyc("to_c3");
    chk("to_held", 8'(gnt), 8'h08);
    cyc("to_fire");
    chk("to_gnt", 8'(gnt), 8'h00);
    chk("to_pulse", 8'(timeout), 8'h01);
    chk("to_lock", 8'(lock), 8'h08);
    cyc("to_next");
    chk("to_next_gnt", 8'(gnt), 8'h02);
    chk("to_pulse_end", 8'(timeout), 8'h00);
    req = 4'b0010;
    cyc("lock_clr");
    chk("lock_clr", 8'(lock), 8'h00);
    req = 4'b0000;
    cyc("idle1");
    cyc("idle2");

    // done on the timeout cycle
    req = 4'b0100;
    cyc("dt_c1");
    cyc("dt_c2");
    cyc("dt_c3");
    done = 1'b1;
    cyc("dt_rel");
    chk("dt_timeout", 8'(timeout), 8'h00);
    chk("dt_lock", 8'(lock), 8'h00);
    done = 1'b0;

    // request drops on the would-be timeout cycle
    cyc("wt_c1");
    cyc("wt_c2");
    cyc("wt_c3");
    req = 4'b0000;
    cyc("wt_rel");
    chk("wt_lock", 8'(lock), 8'h00);
    chk("wt_timeout", 8'(timeout), 8'h00);

    // async reset mid-grant with a lock outstanding
    req = 4'b1000;
    cyc("ar_c1");
    cyc("ar_c2");
    cyc("ar_c3");
    cyc("ar_to");
    req = 4'b1001;
    cyc("ar_g0");
    cyc("ar_hold");
    chk("ar_pre_lock", 8'(lock), 8'h08);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_gnt", 8'(gnt), 8'h00);
    chk("ar_valid", 8'(gnt_valid), 8'h00);
    chk("ar_lock", 8'(lock), 8'h00);
    chk("ar_cnt", 8'(dut.cnt), 8'h00);
    chk("ar_timeout", 8'(timeout), 8'h00);
    cyc("ar_inreset");
    #2;
    rst_n = 1'b1;
    cyc("ar_after");
    chk("ar_after_gnt", 8'(gnt), 8'h08);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 6) == 0);
      cyc("rand");
    end
    done = 1'b0;
    req  = 4'b0000;
    cyc("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_arb4.md
# grant_arb4

Four-requester grant stage. It sits directly downstream of the fixed-priority one-hot selector and registers its decision into a held, one-hot grant. The grant is released on a done handshake, on request withdrawal, or on a bounded hold timeout. Requesters that time out are locked out until they drop their request, so a stuck master cannot starve the others.

## Interface
- `MAX_HOLD`, default 15: maximum cycles a grant may be held. 0 disables the timeout.
- `CNT_W`, default `$clog2(MAX_HOLD+1)` with a minimum of 1: hold-counter width. Derived; not overridden.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  4: request lines. Bit 3 has the highest priority.
- `done`  in  1: pulse from the current grantee ending its transaction. Ignored when no grant is held.
- `gnt`  out  4: registered one-hot grant, or 0.
- `gnt_valid`  out  1: `|gnt`, registered.
- `gnt_id`  out  2: binary index of the granted bit. 0 when idle.
- `timeout`  out  1: one-cycle pulse when a grant is force-released.
- `lock`  out  4: current lockout mask, for debug.

## Operation
- States: IDLE, BUSY.
- Eligible set: `elig = req & ~lock`. Pick = highest set bit of `elig`, one-hot.
- IDLE:
  - `elig != 0`: load `gnt` with the pick, set `gnt_id`, clear the counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: `gnt` is held stable. Higher-priority requests never preempt. Release occurs when any of the following hold, checked in this priority order:
  1. `done == 1`.
  2. `req[gnt_id] == 0`.
  3. `MAX_HOLD != 0` and `cnt == MAX_HOLD-1`. This sets `timeout` and sets `lock[gnt_id]`.
- On release: `gnt`, `gnt_valid` and `gnt_id` go to 0 and the FSM returns to IDLE.
- When not releasing: `cnt` increments, saturating at `MAX_HOLD-1`.
- Simultaneous `done` and timeout condition: `done` wins. `timeout` stays 0 and no lock is set.
- Lock clear: each cycle, `lock[i]` clears when `req[i] == 0`. Clear takes precedence over set for the same bit in the same cycle.
- All-locked case: if every requesting bit is locked, stay in IDLE with `gnt = 0`.
- Width rule: `cnt` is `CNT_W` bits, unsigned. The compare is exact, with no wrap.

## Timing
- Reset values, asserted asynchronously: `gnt = 0`, `gnt_valid = 0`, `gnt_id = 0`, `timeout = 0`, `lock = 0`, `cnt = 0`, state IDLE.
- Reset mid-grant drops `gnt` immediately. No `timeout` pulse is produced.
- Request-to-grant latency: `req` sampled at edge N gives `gnt` valid after edge N. It is registered, never combinational from `req`.
- Release latency: `done` sampled at edge M gives `gnt = 0` after edge M.
- Back-to-back grants: earliest new grant is after edge M+1. The one-cycle gap with `gnt = 0` is mandatory.
- A grant lasts at least 1 cycle and at most `MAX_HOLD` cycles.
- `timeout` is high for exactly the cycle after the forcing edge, aligned with `gnt` falling.

## Structure
- Shared package `arb_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY`), `NREQ = 4`, and a function converting one-hot to index.
- One sub-module, `prio4_onehot`: purely combinational. Input is `elig[3:0]`; output is the highest-priority one-hot pick.
- FSM, counter and lock register live in `grant_arb4`.

## Test plan
- Reset and basic grant:
  - `rst_n` low, then `req = 4'b0101`: after the first edge, `gnt = 4'b0100`, `gnt_id = 2`.
  - `done` pulse: `gnt = 0` for one cycle, then `gnt = 4'b0001`.
- No preemption: grant on `req[0]`, then `req[3]` rises. `gnt` stays `4'b0001` until `done`, then `4'b1000` follows after the one-cycle gap.
- Withdrawal: grant on bit 2, then `req[2]` drops. `gnt = 0` next cycle and `timeout` stays 0.
- Timeout and lockout with `MAX_HOLD = 3`:
  - `req = 4'b1010` held with no `done`: `gnt = 4'b1000` for exactly 3 cycles.
  - `timeout` pulses and `lock = 4'b1000`.
  - Next grant is `4'b0010`.
  - Dropping `req[3]` for one cycle clears `lock[3]`.
- Simultaneous events:
  - `done` on the timeout cycle: no `timeout` pulse, `lock` unchanged.
  - `req[i]` low in the same cycle as the lock-set for bit i: `lock[i]` ends at 0.
- Async reset mid-BUSY: `rst_n` pulsed low between edges. `gnt`, `lock` and `cnt` are 0 immediately, with no `timeout` pulse.
